// File: rtl/axi4_slave_pkg.sv
// Shared types for the AXI4 slave memory arbiter: FSM states, requester sides
// and the width of the per-ownership beat counter.
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_OWN = 2'd1,
    RD_OWN = 2'd2
  } arb_state_e;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } arb_side_e;

  localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/axi4_slave_arb_stats.sv
// Saturating activity counters for the memory arbiter (write beats, read
// beats, conflict cycles). Only built when AXI4_SLAVE_MEM_ARB_STATS_EN is set.
module axi4_slave_arb_stats (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_beat,
  input  logic        rd_beat,
  input  logic        conflict,
  output logic [31:0] stat_wr_beats,
  output logic [31:0] stat_rd_beats,
  output logic [31:0] stat_conflicts
);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stat_wr_beats  <= '0;
      stat_rd_beats  <= '0;
      stat_conflicts <= '0;
    end else begin
      // Counters stick at all-ones rather than wrapping.
      if (wr_beat && (stat_wr_beats != '1)) begin
        stat_wr_beats <= stat_wr_beats + 32'd1;
      end
      if (rd_beat && (stat_rd_beats != '1)) begin
        stat_rd_beats <= stat_rd_beats + 32'd1;
      end
      if (conflict && (stat_conflicts != '1)) begin
        stat_conflicts <= stat_conflicts + 32'd1;
      end
    end
  end

endmodule

// File: rtl/axi4_slave_mem_arbiter.sv
// Single-port memory arbiter between the AXI4 slave write-data and read-data paths.
// Optional statistics counters are enabled with AXI4_SLAVE_MEM_ARB_STATS_EN.
module axi4_slave_mem_arbiter
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 12,
  parameter int MAX_HOLD      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wr_req,
  input  logic                    wr_last,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_gnt,
  input  logic                    rd_req,
  input  logic                    rd_last,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_gnt,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_valid,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              dbg_state
`ifdef AXI4_SLAVE_MEM_ARB_STATS_EN
  ,
  output logic [31:0]             stat_wr_beats,
  output logic [31:0]             stat_rd_beats,
  output logic [31:0]             stat_conflicts
`endif
);

  // Handshake: a beat transfers in the cycle where req and gnt are both high;
  // gnt depends combinationally on req, req must stay stable until granted,
  // and a read's data arrives with rd_data_valid exactly one cycle later.

  localparam logic [HOLD_CNT_W:0] MAX_HOLD_C = MAX_HOLD[HOLD_CNT_W:0];

  arb_state_e                state_q, state_d;
  arb_side_e                 pref_q, pref_d;
  logic [HOLD_CNT_W-1:0]     hold_q, hold_d;
  logic [HOLD_CNT_W:0]       hold_inc;
  logic                      rvalid_q;
  logic                      own_wr, own_rd;
  logic                      other_req, last_acc, end_own;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic                      unused_addr_bits;

  // Effective owner; no grants while reset is held.
  always_comb begin
    own_wr = 1'b0;
    own_rd = 1'b0;
    if (RST) begin
      case (state_q)
        WR_OWN: own_wr = 1'b1;
        RD_OWN: own_rd = 1'b1;
        default: begin
          if (wr_req && rd_req) begin
            own_wr = (pref_q == SIDE_WR);
            own_rd = (pref_q == SIDE_RD);
          end else begin
            own_wr = wr_req;
            own_rd = rd_req;
          end
        end
      endcase
    end
  end

  assign wr_gnt = own_wr & wr_req;
  assign rd_gnt = own_rd & rd_req;

  always_comb begin
    state_d   = state_q;
    pref_d    = pref_q;
    hold_d    = hold_q;
    hold_inc  = {1'b0, hold_q} + 1'b1;
    other_req = own_wr ? rd_req : wr_req;
    last_acc  = own_wr ? wr_last : rd_last;
    end_own   = last_acc || ((hold_inc >= MAX_HOLD_C) && other_req);
    if (wr_gnt || rd_gnt) begin
      if (end_own) begin
        hold_d = '0;
        pref_d = own_wr ? SIDE_RD : SIDE_WR;
        if (other_req) begin
          state_d = own_wr ? RD_OWN : WR_OWN;
        end else begin
          state_d = IDLE;
        end
      end else begin
        state_d = own_wr ? WR_OWN : RD_OWN;
        // Long unsplit bursts saturate the counter instead of wrapping.
        hold_d  = hold_inc[HOLD_CNT_W] ? '1 : hold_inc[HOLD_CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      pref_q   <= SIDE_WR;
      hold_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pref_q   <= pref_d;
      hold_q   <= hold_d;
      rvalid_q <= rd_gnt;
    end
  end

  assign sel_addr         = wr_gnt ? wr_addr : rd_addr;
  assign unused_addr_bits = ^sel_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];

  assign mem_en        = wr_gnt | rd_gnt;
  assign mem_we        = wr_gnt;
  assign mem_addr      = sel_addr[MEM_ADDR_BITS-1:0];
  assign mem_wdata     = wr_data;
  assign mem_be        = wr_gnt ? wr_strb : '0;
  assign rd_data       = mem_rdata;
  assign rd_data_valid = rvalid_q;
  assign dbg_state     = state_q;

`ifdef AXI4_SLAVE_MEM_ARB_STATS_EN
  logic conflict;

  // A requester held off by the effective owner of the other side.
  assign conflict = (wr_req && !wr_gnt && own_rd) || (rd_req && !rd_gnt && own_wr);

  axi4_slave_arb_stats u_stats (
    .CLK            (CLK),
    .RST            (RST),
    .wr_beat        (wr_gnt),
    .rd_beat        (rd_gnt),
    .conflict       (conflict),
    .stat_wr_beats  (stat_wr_beats),
    .stat_rd_beats  (stat_rd_beats),
    .stat_conflicts (stat_conflicts)
  );
`endif

endmodule

// File: tb/tb_axi4_slave_mem_arbiter.sv
// Directed bench for axi4_slave_mem_arbiter with a behavioural synchronous memory
// and a read-data scoreboard; stats checks apply when AXI4_SLAVE_MEM_ARB_STATS_EN is set.
module tb_axi4_slave_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        wr_req, wr_last, wr_gnt;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        rd_req, rd_last, rd_gnt;
  logic [31:0] rd_addr, rd_data;
  logic        rd_data_valid;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;
`ifdef AXI4_SLAVE_MEM_ARB_STATS_EN
  logic [31:0] stat_wr_beats, stat_rd_beats, stat_conflicts;
`endif

  axi4_slave_mem_arbiter dut (
    .CLK           (CLK),
    .RST           (RST),
    .wr_req        (wr_req),
    .wr_last       (wr_last),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_gnt        (wr_gnt),
    .rd_req        (rd_req),
    .rd_last       (rd_last),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rdata     (mem_rdata),
    .dbg_state     (dbg_state)
`ifdef AXI4_SLAVE_MEM_ARB_STATS_EN
    ,
    .stat_wr_beats  (stat_wr_beats),
    .stat_rd_beats  (stat_rd_beats),
    .stat_conflicts (stat_conflicts)
`endif
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural memory with 1-cycle synchronous read
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        prev_gnt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      check("excl_gnt", 32'(wr_gnt & rd_gnt), 32'd0);
      check("rvalid_lat", 32'(rd_data_valid), 32'(prev_gnt));
      if (rd_data_valid) begin
        check("rq_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rdata", rd_data, exp_q.pop_front());
      end
      prev_gnt = rd_gnt;
    end
  end

  // Driver tasks
  task automatic set_wr(input logic req, input logic last, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
    wr_req = req; wr_last = last; wr_addr = addr; wr_data = data; wr_strb = strb;
  endtask

  task automatic set_rd(input logic req, input logic last, input logic [31:0] addr);
    rd_req = req; rd_last = last; rd_addr = addr;
  endtask

  task automatic to_neg();
    @(negedge CLK);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle();
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b0, 1'b0, 32'h0);
    to_neg();
    check("idle_mem_en", 32'(mem_en), 32'd0);
    next_cycle();
  endtask

  initial begin
    RST = 1'b0;
    set_wr(1'b1, 1'b1, 32'h100, 32'h1111_2222, 4'hF);
    set_rd(1'b1, 1'b1, 32'h100);

    // T1: reset with both requesting
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mon_en = 1'b1;
      to_neg();
      check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
      check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
      check("rst_rvalid", 32'(rd_data_valid), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
    end
    next_cycle();
    RST = 1'b1;
    to_neg();
    check("rel_wr_gnt", 32'(wr_gnt), 32'd1);
    check("rel_rd_gnt", 32'(rd_gnt), 32'd0);
    check("rel_mem_we", 32'(mem_we), 32'd1);
    check("rel_mem_addr", 32'(mem_addr), 32'h100);
    next_cycle();
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    to_neg();
    check("t1_rd_gnt", 32'(rd_gnt), 32'd1);
    check("t1_state", 32'(dbg_state), 32'd2);
    exp_q.push_back(32'h1111_2222);
    next_cycle();
    idle_cycle();

    // T2: 4-beat write burst, read-back, partial strobe write
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, i == 3, 32'h10 + 32'(i * 4), 32'hD000_0000 + 32'(i), 4'hF);
      to_neg();
      check("t2_wr_gnt", 32'(wr_gnt), 32'd1);
      check("t2_mem_we", 32'(mem_we), 32'd1);
      check("t2_mem_addr", 32'(mem_addr), 32'h10 + 32'(i * 4));
      check("t2_mem_be", 32'(mem_be), 32'hF);
      check("t2_mem_wdata", mem_wdata, 32'hD000_0000 + 32'(i));
      next_cycle();
    end
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 1'b0, 32'h10);
    to_neg();
    check("t2_rd_gnt0", 32'(rd_gnt), 32'd1);
    check("t2_rd_we", 32'(mem_we), 32'd0);
    check("t2_rd_be", 32'(mem_be), 32'd0);
    exp_q.push_back(32'hD000_0000);
    next_cycle();
    set_rd(1'b1, 1'b1, 32'h1C);
    to_neg();
    check("t2_rd_gnt1", 32'(rd_gnt), 32'd1);
    check("t2_rd_addr", 32'(mem_addr), 32'h1C);
    exp_q.push_back(32'hD000_0003);
    next_cycle();
    set_rd(1'b0, 1'b0, 32'h0);
    set_wr(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h3);
    to_neg();
    check("t2_strb_gnt", 32'(wr_gnt), 32'd1);
    check("t2_strb_be", 32'(mem_be), 32'h3);
    next_cycle();
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 1'b1, 32'h10);
    to_neg();
    check("t2_strb_rd", 32'(rd_gnt), 32'd1);
    exp_q.push_back(32'hD000_FFFF);
    next_cycle();
    idle_cycle();

    // T3: competing 32-beat bursts, hand-over every MAX_HOLD=16 beats
    begin
      int wi = 0;
      int ri = 0;
      logic ew, er;
      for (int c = 0; c < 64; c++) begin
        ew = (c < 16) || (c >= 32 && c < 48);
        er = !ew;
        set_wr(wi < 32, wi == 31, 32'h200 + 32'(wi * 4), 32'hC0DE_0000 + 32'(wi), 4'hF);
        set_rd(ri < 32, ri == 31, 32'h200 + 32'(ri * 4));
        to_neg();
        check("t3_wr_gnt", 32'(wr_gnt), 32'(ew));
        check("t3_rd_gnt", 32'(rd_gnt), 32'(er));
        if (er) exp_q.push_back(32'hC0DE_0000 + 32'(ri));
        if (ew) wi++;
        if (er) ri++;
        next_cycle();
      end
    end
    idle_cycle();

    // T4: write burst with a 2-cycle gap while read waits
    set_rd(1'b0, 1'b0, 32'h0);
    set_wr(1'b1, 1'b0, 32'h400, 32'hAA00_0000, 4'hF);
    to_neg();
    check("t4_b0", 32'(wr_gnt), 32'd1);
    next_cycle();
    set_rd(1'b1, 1'b1, 32'h10);
    for (int i = 1; i < 3; i++) begin
      set_wr(1'b1, 1'b0, 32'h400 + 32'(i * 4), 32'hAA00_0000 + 32'(i), 4'hF);
      to_neg();
      check("t4_wr_gnt", 32'(wr_gnt), 32'd1);
      check("t4_rd_block", 32'(rd_gnt), 32'd0);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      to_neg();
      check("t4_gap_rd", 32'(rd_gnt), 32'd0);
      check("t4_gap_en", 32'(mem_en), 32'd0);
      check("t4_gap_state", 32'(dbg_state), 32'd1);
      next_cycle();
    end
    set_wr(1'b1, 1'b1, 32'h40C, 32'hAA00_0003, 4'hF);
    to_neg();
    check("t4_last_wr", 32'(wr_gnt), 32'd1);
    check("t4_last_rd", 32'(rd_gnt), 32'd0);
    next_cycle();
    set_wr(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    to_neg();
    check("t4_rd_after", 32'(rd_gnt), 32'd1);
    exp_q.push_back(32'hD000_FFFF);
    next_cycle();
    idle_cycle();

    // T5: single-beat requests from both sides alternate
    for (int i = 0; i < 8; i++) begin
      set_wr(i < 7, 1'b1, 32'h600 + 32'(i * 4), 32'hBB00_0000 + 32'(i), 4'hF);
      set_rd(1'b1, 1'b1, (i % 4 == 1) ? 32'h10 : 32'h14);
      to_neg();
      check("t5_wr_gnt", 32'(wr_gnt), 32'(i % 2 == 0));
      check("t5_rd_gnt", 32'(rd_gnt), 32'(i % 2 == 1));
      if (i % 2 == 1) exp_q.push_back((i % 4 == 1) ? 32'hD000_FFFF : 32'hD000_0001);
      next_cycle();
    end
    idle_cycle();

`ifdef AXI4_SLAVE_MEM_ARB_STATS_EN
    to_neg();
    check("stat_wr", stat_wr_beats, 32'd46);
    check("stat_rd", stat_rd_beats, 32'd41);
    check("stat_conf", stat_conflicts, 32'd61);
    next_cycle();
`endif

    // T6: reset the cycle after a read grant, mid-burst
    set_rd(1'b1, 1'b0, 32'h14);
    to_neg();
    check("t6_rd_gnt", 32'(rd_gnt), 32'd1);
    exp_q.push_back(32'hD000_0001);
    next_cycle();
    RST = 1'b0;
    to_neg();
    check("t6_rst_gnt", 32'(rd_gnt), 32'd0);
    check("t6_rvalid_hi", 32'(rd_data_valid), 32'd1);
    next_cycle();
    RST = 1'b1;
    set_rd(1'b0, 1'b0, 32'h0);
    set_wr(1'b1, 1'b1, 32'h700, 32'hCC00_0000, 4'hF);
    to_neg();
    check("t6_rvalid_lo", 32'(rd_data_valid), 32'd0);
    check("t6_state", 32'(dbg_state), 32'd0);
    check("t6_wr_gnt", 32'(wr_gnt), 32'd1);
`ifdef AXI4_SLAVE_MEM_ARB_STATS_EN
    check("t6_stat_wr", stat_wr_beats, 32'd0);
    check("t6_stat_rd", stat_rd_beats, 32'd0);
    check("t6_stat_conf", stat_conflicts, 32'd0);
`endif
    next_cycle();
    idle_cycle();
    idle_cycle();

    check("rq_drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem_arbiter.md
Name: axi4_slave_mem_arbiter

Overview:
Arbitrates the AXI4 slave's single-port slave memory between the write-data path (mem_wr_*) and the read-data path (mem_rd_*).
- Grants the memory to one path per cycle.
- Locks ownership for a whole burst (until the requester's last beat) so bursts are not interleaved.
- Forces a hand-over after MAX_HOLD beats when the other path is waiting.
- Returns read data with a fixed 1-cycle latency.
- Sits between the write-data/read-data channel blocks and the memory array inside axi4_slave_top.

Parameters:
- ADDR_WIDTH, 32, address width of requester ports.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- MEM_ADDR_BITS, 12, memory index width; mem_addr = req_addr[MEM_ADDR_BITS-1:0].
- MAX_HOLD, 16, max consecutive accepted beats per ownership when the other side is requesting; range 1..255.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-low reset
- wr_req  in  1  write beat request
- wr_last  in  1  beat is last of write burst
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_strb  in  DATA_WIDTH/8  byte enables
- wr_gnt  out  1  write beat accepted this cycle
- rd_req  in  1  read beat request
- rd_last  in  1  beat is last of read burst
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read beat accepted this cycle
- rd_data  out  DATA_WIDTH  read data
- rd_data_valid  out  1  rd_data valid (1 cycle after rd_gnt)
- mem_en  out  1  memory access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  MEM_ADDR_BITS  memory index
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data (synchronous read, 1-cycle latency)

Behaviour:
- Reset (RST==0 at posedge): state=IDLE, hold_cnt=0, rr_pref=WRITE, rd_data_valid=0.
  - Combinational outputs evaluate with state=IDLE.
  - Reset mid-burst drops ownership and any pending read response.
- States: IDLE, WR_OWN, RD_OWN. Effective owner per cycle:
  - WR_OWN / RD_OWN: the current state.
  - IDLE: the sole requester, or rr_pref if both request; none if neither requests.
- wr_gnt = owner==WR && wr_req; rd_gnt = owner==RD && rd_req. The two are never both 1. A beat is accepted in the same cycle as its request (0 wait states).
- Memory command is combinational from the accepted beat:
  - mem_en = wr_gnt|rd_gnt; mem_we = wr_gnt.
  - mem_addr = selected addr[MEM_ADDR_BITS-1:0].
  - mem_wdata = wr_data; mem_be = wr_gnt ? wr_strb : 0.
- rd_data_valid <= rd_gnt (registered); rd_data = mem_rdata (passthrough).
- hold_cnt: 8-bit count of beats accepted under the current ownership; cleared on ownership change.
- Transitions at posedge, when the owner's beat is accepted:
  - Accepted beat with last=1: ownership ends.
  - Accepted beat with hold_cnt+1 >= MAX_HOLD and the other side requesting: ownership ends (burst split; the owner resumes later mid-burst).
  - Otherwise: state = owner (lock held).
- On ownership end:
  - Other side requesting: go directly to its OWN state.
  - Else: go to IDLE.
  - rr_pref = the side that just lost ownership's opposite (the other side).
- Owner deasserts req mid-burst: lock held, no grant to the other side (AXI guarantees the burst continues), hold_cnt unchanged.
- IDLE with no requests: no state change, mem_en=0.
- Single-beat bursts (last=1 on the first beat) from both sides alternate each cycle.

Optional Feature:
- Macro: AXI4_SLAVE_MEM_ARB_STATS_EN.
- Defined: adds outputs stat_wr_beats, stat_rd_beats, stat_conflicts, each 32-bit and saturating.
  - stat_wr_beats / stat_rd_beats: count accepted write / read beats.
  - stat_conflicts: counts cycles where a requester is stalled by the other owner.
  - All reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package axi4_slave_pkg:
  - arb_state_e enum {IDLE, WR_OWN, RD_OWN}.
  - arb_side_e enum {SIDE_WR, SIDE_RD}.
  - localparam HOLD_CNT_W=8.
- One sub-module, axi4_slave_arb_stats (the saturating counters), instantiated only under the macro.
- FSM and mux stay in the top module.

Test Plan:
1. Reset: RST=0 for 3 cycles with wr_req=rd_req=1 → wr_gnt=0 (combinational IDLE allows grant after release only), rd_data_valid=0. First cycle after release: wr_gnt=1 (rr_pref=WRITE).
2. Write burst of 4 beats (addr 0x10..0x1C, strb 0xF, last on beat 4) → 4 consecutive wr_gnt, mem_we=1, mem_addr=0x010..0x01C. Read 0x10 afterwards → rd_data_valid 1 cycle after rd_gnt, rd_data = written value.
3. Both request continuously with 32-beat bursts, MAX_HOLD=16 → write owns 16 beats, then read owns 16, then alternation continues. No cycle has both grants.
4. Write burst in progress with rd_req rising and wr_req gapping 2 cycles mid-burst → rd_gnt stays 0 during the gap. Read is granted in the cycle after wr_last is accepted.
5. Single-beat requests from both sides every cycle → grants alternate W,R,W,R. Each read yields rd_data_valid exactly 1 cycle later.
6. Reset asserted the cycle after rd_gnt → rd_data_valid=0, state=IDLE. With AXI4_SLAVE_MEM_ARB_STATS_EN defined, stat counters read 0.
